q_action_selector: RTL and testbench

Epsilon-greedy action selector that reads the Q-table the Q-learning accelerator writes. On a start request it draws a 16-bit pseudo-random number and decides between exploring and exploiting. To explore, it emits a random action. To exploit, it scans all action RAMs for the current state over the Q-table read port, then emits the argmax action with its Q value. Sits between the environment/agent controller and the Q-table read side.

---
 rtl/q_action_selector.sv | 188 ++++++++++++++++++
 tb/tb_q_action_selector.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/q_action_selector.sv
// Epsilon-greedy action selector: an LFSR draw decides between a random action
// and a full argmax scan of one Q-table row over the table's read port.
module q_action_selector #(
  parameter int              NUM_ACTIONS = 15,
  parameter int              ACT_W       = 4,
  parameter int              STATE_W     = 6,
  parameter int              Q_W         = 16,
  parameter logic [15:0]     LFSR_SEED   = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] state,
  input  logic [15:0]        epsilon,
  output logic               busy,
  output logic               q_rd_en,
  output logic [STATE_W-1:0] q_rd_addr,
  output logic [ACT_W-1:0]   q_rd_act,
  input  logic [Q_W-1:0]     q_rd_data,
  output logic               act_valid,
  input  logic               act_ready,
  output logic [ACT_W-1:0]   action,
  output logic [Q_W-1:0]     q_best,
  output logic               explored
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam logic [ACT_W-1:0] LP_NUM  = ACT_W'(NUM_ACTIONS);
  localparam logic [ACT_W-1:0] LP_LAST = ACT_W'(NUM_ACTIONS - 1);

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Maps a raw ACT_W-bit draw into 0..NUM_ACTIONS-1 with a single subtraction.
  function automatic logic [ACT_W-1:0] fold_action(input logic [ACT_W-1:0] r);
    return (r < LP_NUM) ? r : (r - LP_NUM);
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [15:0]        r_lfsr;
  logic               r_rd_en;
  logic [STATE_W-1:0] r_rd_addr;
  logic [ACT_W-1:0]   r_rd_act;
  logic               r_dv;
  logic [ACT_W-1:0]   r_dv_act;
  logic               r_first;
  logic [Q_W-1:0]     r_best;
  logic [ACT_W-1:0]   r_best_act;
  logic               r_act_valid;
  logic [ACT_W-1:0]   r_action;
  logic [Q_W-1:0]     r_q_best;
  logic               r_explored;

  logic [15:0]        w_lfsr_nxt;
  logic               w_explore;
  logic               w_take;
  logic [Q_W-1:0]     w_best;
  logic [ACT_W-1:0]   w_best_act;

  assign w_lfsr_nxt = lfsr_next(r_lfsr);
  assign w_explore  = (epsilon == 16'hFFFF) || (w_lfsr_nxt < epsilon);

  // Running argmax; r_dv marks the cycle the read data for r_dv_act is present.
  assign w_take     = r_dv && (r_first || ($signed(q_rd_data) > $signed(r_best)));
  assign w_best     = w_take ? q_rd_data : r_best;
  assign w_best_act = w_take ? r_dv_act  : r_best_act;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = w_explore ? S_OUT : S_SCAN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SCAN: begin
        if (r_rd_act == LP_LAST) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_SCAN;
        end
      end
      S_DRAIN: w_state_nxt = S_OUT;
      S_OUT: begin
        if (act_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_OUT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: LFSR, read issue, argmax tracking and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr      <= LFSR_SEED;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_act    <= '0;
      r_dv        <= 1'b0;
      r_dv_act    <= '0;
      r_first     <= 1'b1;
      r_best      <= '0;
      r_best_act  <= '0;
      r_act_valid <= 1'b0;
      r_action    <= '0;
      r_q_best    <= '0;
      r_explored  <= 1'b0;
    end else begin
      r_dv       <= r_rd_en;
      r_dv_act   <= r_rd_act;
      r_best     <= w_best;
      r_best_act <= w_best_act;
      if (w_take) begin
        r_first <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_lfsr    <= w_lfsr_nxt;
            r_rd_addr <= state;
            if (w_explore) begin
              r_act_valid <= 1'b1;
              r_action    <= fold_action(w_lfsr_nxt[ACT_W-1:0]);
              r_q_best    <= '0;
              r_explored  <= 1'b1;
            end else begin
              r_rd_en  <= 1'b1;
              r_rd_act <= '0;
              r_first  <= 1'b1;
            end
          end
        end
        S_SCAN: begin
          if (r_rd_act == LP_LAST) begin
            r_rd_en <= 1'b0;
          end else begin
            r_rd_act <= r_rd_act + {{(ACT_W-1){1'b0}}, 1'b1};
          end
        end
        S_DRAIN: begin
          r_act_valid <= 1'b1;
          r_action    <= w_best_act;
          r_q_best    <= w_best;
          r_explored  <= 1'b0;
        end
        S_OUT: begin
          if (act_ready) begin
            r_act_valid <= 1'b0;
          end
        end
        default: r_act_valid <= 1'b0;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign q_rd_en   = r_rd_en;
  assign q_rd_addr = r_rd_addr;
  assign q_rd_act  = r_rd_act;
  assign act_valid = r_act_valid;
  assign action    = r_action;
  assign q_best    = r_q_best;
  assign explored  = r_explored;

endmodule

// File: tb/tb_q_action_selector.sv
// Directed bench for q_action_selector with a one-cycle-latency Q-table model.
module tb_q_action_selector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  state = 6'd0;
  logic [15:0] epsilon = 16'd0;
  logic        busy;
  logic        q_rd_en;
  logic [5:0]  q_rd_addr;
  logic [3:0]  q_rd_act;
  logic [15:0] q_rd_data = 16'hDEAD;
  logic        act_valid;
  logic        act_ready = 1'b0;
  logic [3:0]  action;
  logic [15:0] q_best;
  logic        explored;

  logic [15:0] qmem [0:63][0:15];
  int n_cmp = 0;
  int n_err = 0;

  q_action_selector dut (
    .clk(clk), .rst(rst), .start(start), .state(state), .epsilon(epsilon),
    .busy(busy), .q_rd_en(q_rd_en), .q_rd_addr(q_rd_addr), .q_rd_act(q_rd_act),
    .q_rd_data(q_rd_data), .act_valid(act_valid), .act_ready(act_ready),
    .action(action), .q_best(q_best), .explored(explored)
  );

  always #5 clk = ~clk;

  // Q-table read side: data valid exactly one cycle after the strobe.
  always @(posedge clk) begin
    if (q_rd_en) q_rd_data <= qmem[q_rd_addr][q_rd_act];
    else         q_rd_data <= 16'hDEAD;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag, input logic v, input logic [3:0] a,
                            input logic [15:0] q, input logic e);
    chk({tag, ".act_valid"}, {31'd0, act_valid}, {31'd0, v});
    chk({tag, ".action"},    {28'd0, action},    {28'd0, a});
    chk({tag, ".q_best"},    {16'd0, q_best},    {16'd0, q});
    chk({tag, ".explored"},  {31'd0, explored},  {31'd0, e});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".busy"},  {31'd0, busy},    32'd0);
    chk({tag, ".rd_en"}, {31'd0, q_rd_en}, 32'd0);
    chk({tag, ".addr"},  {26'd0, q_rd_addr}, 32'd0);
    chk({tag, ".act"},   {28'd0, q_rd_act},  32'd0);
    chk_result(tag, 1'b0, 4'd0, 16'd0, 1'b0);
  endtask

  task automatic go(input logic [5:0] st, input logic [15:0] eps);
    state = st; epsilon = eps; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in the first SCAN cycle; ends in the first OUT cycle.
  task automatic scan_check(input string tag, input logic [5:0] st, input int pulse_at);
    for (int i = 0; i < 15; i++) begin
      if (i == pulse_at) begin
        start = 1'b1; state = 6'd20; epsilon = 16'hFFFF;
      end
      chk({tag, ".rd_en"}, {31'd0, q_rd_en}, 32'd1);
      chk({tag, ".addr"},  {26'd0, q_rd_addr}, {26'd0, st});
      chk({tag, ".act"},   {28'd0, q_rd_act}, i);
      chk({tag, ".busy"},  {31'd0, busy}, 32'd1);
      tick();
    end
    chk({tag, ".drain_rd_en"}, {31'd0, q_rd_en}, 32'd0);
    chk({tag, ".drain_valid"}, {31'd0, act_valid}, 32'd0);
    tick();
  endtask

  task automatic accept();
    act_ready = 1'b1;
    tick();
    act_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < 64; s++)
      for (int a = 0; a < 16; a++)
        qmem[s][a] = 16'h0000;
    for (int a = 0; a < 15; a++) begin
      qmem[5][a]  = 16'(a * 256);
      qmem[12][a] = 16'h8000 + 16'(a);
    end
    qmem[5][9]   = 16'h7F00;
    qmem[12][3]  = 16'hFFF0;
    qmem[12][11] = 16'hFFF0;

    // Reset and idle
    #1;
    do_reset();
    chk_reset_vals("reset");
    for (int i = 0; i < 10; i++) begin
      chk("idle.rd_en", {31'd0, q_rd_en}, 32'd0);
      chk("idle.busy", {31'd0, busy}, 32'd0);
      tick();
    end
    chk_reset_vals("idle_end");

    // Exploit, positive row with a single peak
    go(6'd5, 16'h0000);
    scan_check("scan5", 6'd5, -1);
    chk_result("exploit5", 1'b1, 4'd9, 16'h7F00, 1'b0);
    accept();
    chk("exploit5.drop", {31'd0, act_valid}, 32'd0);
    chk("exploit5.idle", {31'd0, busy}, 32'd0);

    // Exploit, negative row with tie at 3 and 11
    go(6'd12, 16'h0000);
    scan_check("scan12", 6'd12, -1);
    chk_result("tie", 1'b1, 4'd3, 16'hFFF0, 1'b0);
    accept();

    // Explore sequence after fresh reset: 59C3, B387, 670F, then CE1E exploit
    do_reset();
    go(6'd7, 16'hFFFF);
    chk_result("explore1", 1'b1, 4'd3, 16'd0, 1'b1);
    chk("explore1.rd_en", {31'd0, q_rd_en}, 32'd0);
    chk("explore1.busy", {31'd0, busy}, 32'd1);
    accept();
    go(6'd7, 16'hFFFF);
    chk_result("explore2", 1'b1, 4'd7, 16'd0, 1'b1);
    accept();
    go(6'd7, 16'h6710);
    chk_result("explore_fold", 1'b1, 4'd0, 16'd0, 1'b1);
    accept();
    go(6'd5, 16'hCE1E);
    chk("eq_eps.valid", {31'd0, act_valid}, 32'd0);
    scan_check("eq_eps", 6'd5, -1);
    chk_result("eq_eps", 1'b1, 4'd9, 16'h7F00, 1'b0);
    accept();

    // Back-pressure with stray starts during SCAN and OUT (lfsr -> 9C3C)
    go(6'd5, 16'h0000);
    scan_check("bp", 6'd5, 4);
    for (int i = 0; i < 6; i++) begin
      chk_result("bp_hold", 1'b1, 4'd9, 16'h7F00, 1'b0);
      chk("bp_hold.addr", {26'd0, q_rd_addr}, 32'd5);
      tick();
    end
    act_ready = 1'b1;
    tick();
    act_ready = 1'b0;
    start = 1'b0;
    chk("bp.drop", {31'd0, act_valid}, 32'd0);
    chk("bp.busy", {31'd0, busy}, 32'd0);
    tick();
    chk("bp.no_queue", {31'd0, busy}, 32'd0);
    go(6'd7, 16'hFFFF);
    chk_result("bp.lfsr", 1'b1, 4'd9, 16'd0, 1'b1);
    accept();

    // Reset at scan index 7 together with start
    go(6'd5, 16'h0000);
    for (int i = 0; i < 7; i++) tick();
    chk("mid.act7", {28'd0, q_rd_act}, 32'd7);
    rst = 1'b1; start = 1'b1; epsilon = 16'hFFFF;
    tick();
    rst = 1'b0; start = 1'b0;
    chk_reset_vals("mid_rst");
    for (int i = 0; i < 3; i++) tick();
    chk_reset_vals("post_rst");
    go(6'd7, 16'hFFFF);
    chk_result("reseed", 1'b1, 4'd3, 16'd0, 1'b1);
    accept();
    chk("reseed.idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
